// File: rtl/branch_cmp_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : branch_cmp_pipe_pkg                                    |
// | Description : Shared funct3 encodings, latency bounds and helper     |
// |               functions for the pipelined RV32I branch comparator.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package branch_cmp_pipe_pkg;

  // RV32I branch funct3 encodings
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Supported pipeline depths
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;

  // 010 and 011 are the only unused encodings in the branch opcode space
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  // Branch decision from the three comparison flags
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic       zero,
                                        input logic       lt,
                                        input logic       ltu);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:  t = zero;
      F3_BNE:  t = ~zero;
      F3_BLT:  t = lt;
      F3_BGE:  t = ~lt;
      F3_BLTU: t = ltu;
      F3_BGEU: t = ~ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cmp_pipe_zero_reduce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : zero_reduce                                            |
// | Description : Chunked zero detector. Emits one "all zero" bit per    |
// |               CHUNK-wide slice of the input word.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module zero_reduce #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH/CHUNK-1:0] o_chunk_zero
);

  localparam int NCHUNK = WIDTH / CHUNK;

  generate
    for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
      assign o_chunk_zero[g] = ~|i_data[g*CHUNK +: CHUNK];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/branch_cmp_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : branch_cmp_pipe                                        |
// | Description : Pipelined RV32I branch comparator. Registers zero/lt/  |
// |               ltu flags and the taken decision with LAT = 1 or 2     |
// |               cycles of latency, valid tracking and flush.           |
// |               Optional macro BRANCH_STATS_EN adds taken/valid        |
// |               event counters.                                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module branch_cmp_pipe
  import branch_cmp_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  output logic             zero,
  output logic             lt,
  output logic             ltu,
  output logic             taken,
  output logic             illegal
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      taken_cnt,
  output logic [31:0]      valid_cnt
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;

  // Borrow-extended difference drives all three flags
  logic [WIDTH:0]      w_diff;
  logic                w_lt;
  logic                w_ltu;
  logic [NCHUNK-1:0]   w_chunk_zero;
  logic                w_accept;

  assign w_diff   = {1'b0, a} - {1'b0, b};
  assign w_ltu    = w_diff[WIDTH];
  // Differing sign bits: the negative operand is the smaller one
  assign w_lt     = (a[WIDTH-1] ^ b[WIDTH-1]) ? a[WIDTH-1] : w_diff[WIDTH-1];
  assign w_accept = in_valid & ~flush;

  zero_reduce #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) u_zero_reduce (
    .i_data       (w_diff[WIDTH-1:0]),
    .o_chunk_zero (w_chunk_zero)
  );

  generate
    if (WIDTH < 8 || (WIDTH % CHUNK) != 0) begin : g_bad_width
      $error("branch_cmp_pipe: WIDTH must be >= 8 and a multiple of CHUNK");
    end

    if (LAT == LAT_MIN) begin : g_lat1
      logic w_zero;
      assign w_zero = &w_chunk_zero;

      // Single stage: flags update only on accepted operations, taken/illegal gated by valid
      always_ff @(posedge clk) begin
        if (reset) begin
          out_valid <= 1'b0;
          zero      <= 1'b0;
          lt        <= 1'b0;
          ltu       <= 1'b0;
          taken     <= 1'b0;
          illegal   <= 1'b0;
        end else begin
          out_valid <= w_accept;
          if (w_accept) begin
            zero    <= w_zero;
            lt      <= w_lt;
            ltu     <= w_ltu;
            taken   <= branch_taken(funct3, w_zero, w_lt, w_ltu);
            illegal <= f3_illegal(funct3);
          end else begin
            taken   <= 1'b0;
            illegal <= 1'b0;
          end
        end
      end
    end else if (LAT == LAT_MAX) begin : g_lat2
      logic              r_s1_valid;
      logic [NCHUNK-1:0] r_s1_chunk;
      logic              r_s1_lt;
      logic              r_s1_ltu;
      logic [2:0]        r_s1_f3;
      logic              w_s2_zero;
      logic              w_s2_go;

      assign w_s2_zero = &r_s1_chunk;
      // Flush also kills the operation sitting in stage 1
      assign w_s2_go   = r_s1_valid & ~flush;

      // Stage 1: partial zero bits, sign/borrow flags and branch type
      always_ff @(posedge clk) begin
        if (reset) begin
          r_s1_valid <= 1'b0;
          r_s1_chunk <= '0;
          r_s1_lt    <= 1'b0;
          r_s1_ltu   <= 1'b0;
          r_s1_f3    <= 3'b000;
        end else begin
          r_s1_valid <= w_accept;
          if (w_accept) begin
            r_s1_chunk <= w_chunk_zero;
            r_s1_lt    <= w_lt;
            r_s1_ltu   <= w_ltu;
            r_s1_f3    <= funct3;
          end
        end
      end

      // Stage 2: final zero reduction, branch decision and output registers
      always_ff @(posedge clk) begin
        if (reset) begin
          out_valid <= 1'b0;
          zero      <= 1'b0;
          lt        <= 1'b0;
          ltu       <= 1'b0;
          taken     <= 1'b0;
          illegal   <= 1'b0;
        end else begin
          out_valid <= w_s2_go;
          if (w_s2_go) begin
            zero    <= w_s2_zero;
            lt      <= r_s1_lt;
            ltu     <= r_s1_ltu;
            taken   <= branch_taken(r_s1_f3, w_s2_zero, r_s1_lt, r_s1_ltu);
            illegal <= f3_illegal(r_s1_f3);
          end else begin
            taken   <= 1'b0;
            illegal <= 1'b0;
          end
        end
      end
    end else begin : g_bad_lat
      $error("branch_cmp_pipe: LAT must be 1 or 2");
    end
  endgenerate

`ifdef BRANCH_STATS_EN
  // Event counters observe the registered outputs; only reset clears them
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt <= 32'd0;
      valid_cnt <= 32'd0;
    end else begin
      if (out_valid)         valid_cnt <= valid_cnt + 32'd1;
      if (out_valid & taken) taken_cnt <= taken_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_cmp_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_branch_cmp_pipe                                     |
// | Description : Self-checking bench for branch_cmp_pipe. Drives LAT=1  |
// |               and LAT=2 instances with the same stimulus and checks  |
// |               both against an arithmetic reference model.            |
// |               Honours BRANCH_STATS_EN for the counter outputs.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_branch_cmp_pipe;

  localparam int MAXE = 1024;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid;
  logic [31:0] a, b;
  logic [2:0]  funct3;

  logic ov1, z1, lt1, ltu1, tk1, il1;
  logic ov2, z2, lt2, ltu2, tk2, il2;
`ifdef BRANCH_STATS_EN
  logic [31:0] tc1, vc1, tc2, vc2;
`endif

  int checks = 0;
  int errors = 0;

  // Per-edge stimulus history
  logic        op_v [MAXE];
  logic [31:0] op_a [MAXE];
  logic [31:0] op_b [MAXE];
  logic [2:0]  op_f [MAXE];
  logic        kill [MAXE];
  logic        rst_e[MAXE];
  int          e = 0;

  // Reference model state per instance (index 0: LAT=1, index 1: LAT=2)
  logic hz[2], hl[2], hu[2];
  logic prev_ov[2], prev_tk[2];
  int   vcnt[2], tcnt[2];

  always #5 clk = ~clk;

  branch_cmp_pipe #(.WIDTH(32), .CHUNK(8), .LAT(1)) u_l1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .a(a), .b(b), .funct3(funct3),
    .out_valid(ov1), .zero(z1), .lt(lt1), .ltu(ltu1), .taken(tk1), .illegal(il1)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(tc1), .valid_cnt(vc1)
`endif
  );

  branch_cmp_pipe #(.WIDTH(32), .CHUNK(8), .LAT(2)) u_l2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .a(a), .b(b), .funct3(funct3),
    .out_valid(ov2), .zero(z2), .lt(lt2), .ltu(ltu2), .taken(tk2), .illegal(il2)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(tc2), .valid_cnt(vc2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, obs, exp);
    end
  endtask

  // Expected outputs after edge e for the instance with latency lat
  task automatic eval(input int li, input int lat);
    int          src;
    logic        ev, et, ei;
    logic [31:0] sa, sb;
    logic [2:0]  sf;
    src = e - lat + 1;
    if (rst_e[e]) begin
      vcnt[li] = 0;
      tcnt[li] = 0;
    end else begin
      vcnt[li] += int'(prev_ov[li]);
      tcnt[li] += int'(prev_ov[li] & prev_tk[li]);
    end
    ev = 1'b0;
    sf = 3'b000;
    if (src >= 0 && op_v[src]) begin
      ev = 1'b1;
      // Any flush or reset while the operation is in flight drops it
      for (int j = src; j <= e; j++) if (kill[j]) ev = 1'b0;
    end
    if (rst_e[e]) begin
      hz[li] = 1'b0; hl[li] = 1'b0; hu[li] = 1'b0;
    end else if (ev) begin
      sa = op_a[src]; sb = op_b[src]; sf = op_f[src];
      hz[li] = (sa == sb);
      hl[li] = ($signed(sa) < $signed(sb));
      hu[li] = (sa < sb);
    end
    et = 1'b0; ei = 1'b0;
    if (ev) begin
      case (sf)
        3'd0: et = hz[li];
        3'd1: et = !hz[li];
        3'd4: et = hl[li];
        3'd5: et = !hl[li];
        3'd6: et = hu[li];
        3'd7: et = !hu[li];
        default: ei = 1'b1;
      endcase
    end
    prev_ov[li] = ev;
    prev_tk[li] = et;
    if (li == 0) begin
      chk("L1 out_valid", {31'd0, ov1},  {31'd0, ev});
      chk("L1 zero",      {31'd0, z1},   {31'd0, hz[li]});
      chk("L1 lt",        {31'd0, lt1},  {31'd0, hl[li]});
      chk("L1 ltu",       {31'd0, ltu1}, {31'd0, hu[li]});
      chk("L1 taken",     {31'd0, tk1},  {31'd0, et});
      chk("L1 illegal",   {31'd0, il1},  {31'd0, ei});
`ifdef BRANCH_STATS_EN
      chk("L1 valid_cnt", vc1, vcnt[li]);
      chk("L1 taken_cnt", tc1, tcnt[li]);
`endif
    end else begin
      chk("L2 out_valid", {31'd0, ov2},  {31'd0, ev});
      chk("L2 zero",      {31'd0, z2},   {31'd0, hz[li]});
      chk("L2 lt",        {31'd0, lt2},  {31'd0, hl[li]});
      chk("L2 ltu",       {31'd0, ltu2}, {31'd0, hu[li]});
      chk("L2 taken",     {31'd0, tk2},  {31'd0, et});
      chk("L2 illegal",   {31'd0, il2},  {31'd0, ei});
`ifdef BRANCH_STATS_EN
      chk("L2 valid_cnt", vc2, vcnt[li]);
      chk("L2 taken_cnt", tc2, tcnt[li]);
`endif
    end
  endtask

  // One clock: drive inputs, record them at the edge, check both instances 1ns later
  task automatic step(input logic r, input logic f, input logic v,
                      input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] f3);
    reset = r; flush = f; in_valid = v; a = ia; b = ib; funct3 = f3;
    @(posedge clk);
    if (e >= MAXE) begin
      $display("FAIL history overflow edge=%0d limit=%0d", e, MAXE);
      $fatal(1, "history overflow");
    end
    op_v[e] = v; op_a[e] = ia; op_b[e] = ib; op_f[e] = f3;
    kill[e] = r | f; rst_e[e] = r;
    #1;
    eval(0, 1);
    eval(1, 2);
    e++;
  endtask

  initial begin
    logic        rr, rf, rv;
    logic [31:0] ra, rb;
    logic [2:0]  rf3;
    for (int i = 0; i < 2; i++) begin
      hz[i] = 1'b0; hl[i] = 1'b0; hu[i] = 1'b0;
      prev_ov[i] = 1'b0; prev_tk[i] = 1'b0;
      vcnt[i] = 0; tcnt[i] = 0;
    end
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; a = '0; b = '0; funct3 = '0;
    #2;

    // Reset held three cycles, then released idle
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);

    // Back-to-back stream of directed operations
    step(1'b0, 1'b0, 1'b1, 32'd5,        32'd5,        3'b000); // BEQ
    step(1'b0, 1'b0, 1'b1, 32'd5,        32'd5,        3'b001); // BNE
    step(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        3'b100); // BLT
    step(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        3'b110); // BLTU
    step(1'b0, 1'b0, 1'b1, 32'h80000000, 32'h7FFFFFFF, 3'b101); // BGE
    step(1'b0, 1'b0, 1'b1, 32'h80000000, 32'h7FFFFFFF, 3'b111); // BGEU
    step(1'b0, 1'b0, 1'b1, 32'd0,        32'd0,        3'b010); // illegal
    step(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000);
    step(1'b0, 1'b0, 1'b1, 32'd0,        32'd0,        3'b110);
    step(1'b0, 1'b0, 1'b0, 32'd0,        32'd0,        3'b000);
    step(1'b0, 1'b0, 1'b0, 32'd0,        32'd0,        3'b000);

    // Flush kills both in-flight operations; the next one proceeds
    step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 3'b000);
    step(1'b0, 1'b1, 1'b1, 32'd1, 32'd1, 3'b000);
    step(1'b0, 1'b0, 1'b1, 32'd2, 32'd2, 3'b000);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);

    // Randomised traffic with occasional flush and reset
    for (int n = 0; n < 400; n++) begin
      rr  = ($urandom_range(0, 99) < 2);
      rf  = ($urandom_range(0, 99) < 8);
      rv  = ($urandom_range(0, 99) < 80);
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ 32'h80000000;
        2:       rb = ra + 32'd1;
        default: rb = $urandom;
      endcase
      rf3 = 3'($urandom_range(0, 7));
      step(rr, rf, rv, ra, rb, rf3);
    end

    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
